// File: rtl/trace_mon_pkg.sv
// Shared types and helpers for the trace monitor: default widths, the channel-index
// width function, and the event record used for snapshots and the output register.
package trace_mon_pkg;

  localparam int DEF_NUM_CH = 4;
  localparam int DEF_DATA_W = 5;
  localparam int DEF_TS_W   = 32;

  // Record fields are sized for the largest supported build; narrower builds zero-extend.
  localparam int MAX_TS_W   = 64;
  localparam int MAX_ID_W   = 4;
  localparam int MAX_DATA_W = 32;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  typedef struct packed {
    logic [MAX_TS_W-1:0]   ts;
    logic [MAX_ID_W-1:0]   id;
    logic [MAX_DATA_W-1:0] data;
  } trace_rec_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after ptr,
// searching upward and wrapping modulo N.
module rr_arbiter
  import trace_mon_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt_onehot,
  output logic [IW-1:0] gnt_idx,
  output logic          any_gnt
);

  always_comb begin
    int idx;
    // NOTE: every output gets a default before the search so no path leaves it unassigned (latch).
    idx        = 0;
    gnt_onehot = '0;
    gnt_idx    = '0;
    any_gnt    = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!any_gnt && req[idx]) begin
        any_gnt         = 1'b1;
        gnt_idx         = IW'(idx);
        gnt_onehot[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/trace_monitor_sched.sv
// Value-change monitor: detects per-channel changes, timestamps them, and shares one
// registered valid/ready event output among channels through a round-robin scheduler.
module trace_monitor_sched
  import trace_mon_pkg::*;
#(
  parameter  int NUM_CH = DEF_NUM_CH,
  parameter  int DATA_W = DEF_DATA_W,
  parameter  int TS_W   = DEF_TS_W,
  localparam int ID_W   = clog2(NUM_CH)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     mon_en,
  input  logic [NUM_CH-1:0]        ch_mask,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  input  logic                     ovf_clr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [TS_W-1:0]          out_ts,
  output logic [ID_W-1:0]          out_id,
  output logic [DATA_W-1:0]        out_data,
  output logic [NUM_CH-1:0]        ovf
);

  logic [DATA_W-1:0] w_cur  [NUM_CH];
  logic [DATA_W-1:0] r_prev [NUM_CH];
  trace_rec_t        w_new  [NUM_CH];
  trace_rec_t        r_snap [NUM_CH];
  trace_rec_t        r_out;
  trace_rec_t        w_gnt_rec;

  logic [TS_W-1:0]   r_ts;
  logic [NUM_CH-1:0] r_pend, r_en_q, r_ovf;
  logic [NUM_CH-1:0] w_eff, w_det, w_req, w_take, w_pend_nxt, w_ovf_set, w_gnt_onehot;
  logic [ID_W-1:0]   r_rr_ptr, w_gnt_idx;
  logic              r_out_valid, w_free, w_any_gnt, w_unused_rec;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      w_cur[i] = ch_data[i*DATA_W +: DATA_W];
      w_new[i] = '{ts: MAX_TS_W'(r_ts), id: MAX_ID_W'(i), data: MAX_DATA_W'(w_cur[i])};
      w_det[i] = w_eff[i] & ((w_cur[i] != r_prev[i]) | ~r_en_q[i]);
    end
  end

  assign w_eff = {NUM_CH{mon_en}} & ch_mask;
  // A channel detecting this cycle competes immediately; its record is bypassed from w_new.
  assign w_req  = (r_pend & w_eff) | w_det;
  assign w_free = ~r_out_valid | out_ready;
  assign w_take = w_free ? w_gnt_onehot : '0;

  // Grant+detect on a pending channel: old snapshot leaves, the new one stays pending.
  assign w_pend_nxt = w_eff & ((w_det & (r_pend | ~w_take)) | (~w_det & r_pend & ~w_take));
  assign w_ovf_set  = w_det & r_pend & ~w_take;
  assign w_gnt_rec  = r_pend[w_gnt_idx] ? r_snap[w_gnt_idx] : w_new[w_gnt_idx];

  rr_arbiter #(.N(NUM_CH)) u_arb (
    .req        (w_req),
    .ptr        (r_rr_ptr),
    .gnt_onehot (w_gnt_onehot),
    .gnt_idx    (w_gnt_idx),
    .any_gnt    (w_any_gnt)
  );

  // NOTE: snapshots and prev carry no reset; pending bits alone decide whether a snapshot is live.
  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_CH; i++) begin
      r_prev[i] <= w_cur[i];
      if (w_det[i]) r_snap[i] <= w_new[i];
    end
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_ts        <= '0;
      r_pend      <= '0;
      r_en_q      <= '0;
      r_ovf       <= '0;
      r_out_valid <= 1'b0;
      r_out       <= '0;
      r_rr_ptr    <= '0;
    end else begin
      r_ts   <= r_ts + TS_W'(1);
      r_en_q <= w_eff;
      r_pend <= w_pend_nxt;
      r_ovf  <= (r_ovf & ~{NUM_CH{ovf_clr}}) | w_ovf_set;
      if (w_free) begin
        r_out_valid <= w_any_gnt;
        if (w_any_gnt) begin
          r_out    <= w_gnt_rec;
          r_rr_ptr <= (w_gnt_idx == ID_W'(NUM_CH - 1)) ? '0 : w_gnt_idx + ID_W'(1);
        end
      end
    end
  end

  assign out_valid    = r_out_valid;
  assign out_ts       = r_out.ts[TS_W-1:0];
  assign out_id       = r_out.id[ID_W-1:0];
  assign out_data     = r_out.data[DATA_W-1:0];
  assign ovf          = r_ovf;
  assign w_unused_rec = ^r_out;

endmodule

// File: tb/tb_trace_monitor_sched.sv
// Directed bench for trace_monitor_sched built with a 4-bit timestamp so the wrap is reachable.
module tb_trace_monitor_sched;

  localparam int NCH = 4;
  localparam int DW  = 5;
  localparam int TW  = 4;

  logic              clock     = 1'b0;
  logic              reset     = 1'b1;
  logic              mon_en    = 1'b0;
  logic              ovf_clr   = 1'b0;
  logic              out_ready = 1'b1;
  logic [NCH-1:0]    ch_mask   = '0;
  logic [DW-1:0]     d [NCH];
  logic [NCH*DW-1:0] ch_data;
  logic              out_valid;
  logic [TW-1:0]     out_ts;
  logic [1:0]        out_id;
  logic [DW-1:0]     out_data;
  logic [NCH-1:0]    ovf;
  logic [TW-1:0]     ts_model = '0;
  int                n_checks = 0;
  int                n_fail   = 0;

  always #5 clock = ~clock;
  assign ch_data = {d[3], d[2], d[1], d[0]};

  trace_monitor_sched #(.NUM_CH(NCH), .DATA_W(DW), .TS_W(TW)) dut (
    .clock     (clock),
    .reset     (reset),
    .mon_en    (mon_en),
    .ch_mask   (ch_mask),
    .ch_data   (ch_data),
    .ovf_clr   (ovf_clr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ts    (out_ts),
    .out_id    (out_id),
    .out_data  (out_data),
    .ovf       (ovf)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic check_rec(input string tag, input logic [1:0] id, input logic [DW-1:0] data,
                           input logic [TW-1:0] ts);
    check(tag, 64'({out_valid, out_id, out_data, out_ts}), 64'({1'b1, id, data, ts}));
  endtask

  task automatic check_idle(input string tag);
    check(tag, 64'(out_valid), 64'd0);
  endtask

  // One clock; ts_model tracks the value the DUT timestamp holds in the following cycle.
  task automatic step();
    logic r;
    r = reset;
    @(posedge clock);
    #1;
    ts_model = r ? '0 : ts_model + TW'(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [TW-1:0] t;
    logic [TW-1:0] t4;
    for (int i = 0; i < NCH; i++) d[i] = '0;

    // Reset, then the enable-rise report of ch0 one cycle after release.
    mon_en  = 1'b1;
    ch_mask = 4'b0001;
    d[0]    = 5'b10101;
    step();
    step();
    check("rst_out", 64'({out_valid, out_id, out_data, out_ts}), 64'd0);
    check("rst_ovf", 64'(ovf), 64'd0);
    reset = 1'b0;
    t = ts_model;
    step();
    check_rec("first_rec", 2'd0, 5'b10101, t);
    check("first_ts0", 64'(out_ts), 64'd0);
    step();
    check_idle("first_only_a");
    step();
    check_idle("first_only_b");

    // Unmasking ch1..3 reports their current values, continuing from rr_ptr=1.
    ch_mask = 4'b1111;
    t = ts_model;
    for (int k = 1; k < NCH; k++) begin
      step();
      check_rec("en_rise", 2'(k), 5'd0, t);
    end
    step();
    check_idle("en_rise_end");

    // Two simultaneous bursts: ids 0..3 back to back, same timestamp each time.
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < NCH; i++) d[i] = 5'(8 * b + i + 1);
      t = ts_model;
      for (int i = 0; i < NCH; i++) begin
        step();
        check_rec("burst", 2'(i), 5'(8 * b + i + 1), t);
      end
      step();
      check_idle("burst_end");
    end

    // Back-pressure: output holds, ch1 keeps only its last value and flags overflow.
    out_ready = 1'b0;
    d[0] = 5'b10000;
    t  = ts_model;
    t4 = '0;
    step();
    for (int k = 0; k < 10; k++) begin
      if (k == 0) d[1] = 5'b11111;
      if (k == 2) d[1] = 5'b11110;
      if (k == 4) begin
        d[1] = 5'b11101;
        t4 = ts_model;
      end
      step();
      check_rec("hold", 2'd0, 5'b10000, t);
    end
    check("ovf_set", 64'(ovf), 64'b0010);
    out_ready = 1'b1;
    step();
    check_rec("last_wins", 2'd1, 5'b11101, t4);
    step();
    check_idle("ovf_drain");
    check("ovf_sticky", 64'(ovf), 64'b0010);
    ovf_clr = 1'b1;
    step();
    check("ovf_clr", 64'(ovf), 64'd0);
    ovf_clr = 1'b0;

    // Monitor-off window on ch2, then exactly one report of the current value.
    ch_mask = 4'b0100;
    mon_en  = 1'b0;
    for (int k = 0; k < 4; k++) begin
      d[2] = 5'(k + 1);
      step();
      check_idle("mon_off");
    end
    mon_en = 1'b1;
    t = ts_model;
    step();
    check_rec("re_enable", 2'd2, 5'd4, t);
    step();
    check_idle("re_enable_once_a");
    step();
    check_idle("re_enable_once_b");

    // Timestamp wrap: events stamped 15 and then 0.
    for (int k = 0; k < 20 && ts_model != 4'd15; k++) step();
    d[2] = 5'b11000;
    step();
    check_rec("wrap_15", 2'd2, 5'b11000, 4'd15);
    d[2] = 5'b11001;
    step();
    check_rec("wrap_0", 2'd2, 5'b11001, 4'd0);
    step();
    check_idle("wrap_end");

    // Reset mid-flight: record held, two pending, ovf[0] set; all discarded.
    out_ready = 1'b0;
    ch_mask   = 4'b1111;
    t = ts_model;
    step();
    check_rec("pre_rst", 2'd3, 5'b01100, t);
    d[0] = 5'b00111;
    step();
    check("pre_rst_ovf", 64'(ovf), 64'b0001);
    check_rec("pre_rst_hold", 2'd3, 5'b01100, t);
    reset = 1'b1;
    step();
    check("mid_rst_out", 64'({out_valid, out_id, out_data, out_ts}), 64'd0);
    check("mid_rst_ovf", 64'(ovf), 64'd0);
    reset     = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < NCH; i++) begin
      step();
      check_rec("post_rst", 2'(i), d[i], 4'd0);
    end
    step();
    check_idle("post_rst_end");
    check("post_rst_ovf", 64'(ovf), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/trace_monitor_sched.md
Name: trace_monitor_sched

Overview:
Hardware analogue of the simulation-only value monitor. It watches NUM_CH data channels (port IDs, status words) and detects value changes. Each detected change is timestamped and queued, and a round-robin scheduler shares one registered event output among the channels. The output drives the team's trace/log sink over a valid/ready handshake. Global and per-channel enables give monitor-on/monitor-off control in hardware.

Parameters:
NUM_CH, 4, number of watched channels (2..16).
DATA_W, 5, width of each watched value.
TS_W, 32, timestamp counter width.
ID_W, clog2(NUM_CH), channel-index width (derived; not overridden).

Ports:
clock  in  1  system clock, rising edge.
reset  in  1  synchronous, active-high reset.
mon_en  in  1  global monitor enable.
ch_mask  in  NUM_CH  per-channel enable; bit i=1 means channel i is monitored.
ch_data  in  NUM_CH*DATA_W  watched values; channel i occupies bits [i*DATA_W +: DATA_W].
ovf_clr  in  1  clears all ovf bits.
out_valid  out  1  event record valid.
out_ready  in  1  sink accepts the record.
out_ts  out  TS_W  timestamp of the event.
out_id  out  ID_W  channel index.
out_data  out  DATA_W  value captured at the event.
ovf  out  NUM_CH  sticky flags: a pending event of channel i was overwritten before it was sent.

Behaviour:
- Reset, on a synchronous edge with reset=1:
  - ts=0, pending=0, out_valid=0, out_ts/out_id/out_data=0, ovf=0, rr_ptr=0, en_q=0.
  - prev[i] loads ch_data[i].
  - A reset asserted mid-operation discards all pending and in-flight events, with no partial output.
- ts: free-running after reset, +1 per cycle, wraps 2^TS_W-1 -> 0 with no flag.
- Effective enable: eff[i] = mon_en & ch_mask[i]. en_q[i] is the registered eff[i].
- prev[i] takes ch_data[i] every cycle, whether or not the channel is enabled.
- Detection in cycle c, for channel i: det[i] = eff[i] & ((ch_data[i] != prev[i]) | ~en_q[i]).
  - An enable rise therefore reports the current value once. This also covers the first cycle after reset when enabled.
- On det[i] at edge c:
  - pending[i] is set.
  - snap_data[i] takes ch_data[i].
  - snap_ts[i] takes the ts value held during cycle c.
  - If pending[i] was already set and the event is not being consumed this edge, the snapshot is overwritten (latest wins) and ovf[i] is set.
- When eff[i]=0, pending[i] is cleared at the next edge with no output and no ovf.
- Output register is free when out_valid=0 or out_ready=1.
  - If free and any pending bit is set, the round-robin arbiter grants the first pending channel at or after rr_ptr (modulo NUM_CH).
  - out_* load that channel's snapshot, out_valid=1, pending[g] clears, rr_ptr=g+1 (wraps to 0).
  - If free and nothing is pending, out_valid=0 at the next edge.
- Grant and detection on the same channel in the same cycle: the old snapshot is output, pending stays set with the new snapshot, and ovf is not set.
- Hold rule: while out_valid=1 and out_ready=0, all out_* stay stable.
- Latency: an input change visible in cycle c gives out_valid=1 in cycle c+1 at the earliest, if the output is free and the channel wins arbitration. Throughput is 1 event per cycle.
- ovf: sticky. ovf_clr clears all bits at the next edge. A set and a clear on the same bit in the same cycle leaves the bit set.
- mon_en dropping while out_valid=1: the already-registered record is still delivered.

Decomposition:
- Package trace_mon_pkg holds:
  - the clog2 function used for ID_W;
  - localparams for default widths;
  - typedef trace_rec_t {ts, id, data} for out_* and the snapshot storage.
- Sub-module rr_arbiter (parameter N): inputs req[N] and ptr; outputs gnt_onehot, gnt_idx and any_gnt; purely combinational.
- The top level holds detection, snapshots, timestamp and output register.

Test Plan:
- Reset with mon_en=1, ch_mask=4'b0001, ch0=5'b10101, out_ready=1 -> one record, id=0, data=10101, ts=0, one cycle after reset release; no other records.
- All channels enabled, ch0..ch3 change in the same cycle, out_ready=1 -> four records on consecutive cycles, ids 0,1,2,3, all with the same ts; next simultaneous burst starts at id 0 again (rr_ptr wrapped).
- out_ready=0 for 10 cycles while ch1 changes 3 times -> out_* stable; once ready, ch1 delivers only the last value; ovf[1]=1; ovf_clr clears it.
- mon_en=0 for cycles 11..14 while ch2 changes each cycle (mirrors the monitoroff window), then mon_en=1 -> no records during the window; exactly one record with the current ch2 value after re-enable.
- ts preloaded near wrap (TS_W=4 build), change across the wrap -> out_ts=15 then 0, no glitch.
- Assert reset while two events pending and out_valid=1 -> next cycle out_valid=0, ovf=0; no stale records after release.
